// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI slave block.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized value. STAGES must be >= 2.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign q_o    = r_sync[STAGES-1];
    assign rise_o = r_sync[STAGES-1] & ~r_prev;
    assign fall_o = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave running entirely in the clk_i domain: oversampled sclk/cs_n,
// byte-wide RX output and a single-entry TX holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = SPI_FILL_BYTE,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  cs_ni,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_underrun_o,
    output logic                  frame_err_o,
    output spi_slv_state_t        dbg_state_o
);

    localparam int FW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [FW-1:0] FLUSH_MAX = FW'(SYNC_STAGES);

    logic                  w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic                  w_cs_q, w_cs_rise, w_cs_fall;
    logic                  w_mosi;
    logic                  w_start, w_end, w_shift_in, w_fall_act, w_reload, w_load;
    logic                  w_wr, w_flushed;
    logic [SPI_BYTE_W-1:0] w_load_byte;

    spi_slv_state_t        r_state;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_rx_shift, r_tx_shift, r_hold, r_rx_data;
    logic                  r_hold_full, r_miso_oe, r_rx_valid, r_tx_underrun, r_frame_err;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [FW-1:0]         r_flush_cnt;
    logic                  r_armed;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sclk_i),
        .q_o    (w_sclk_q),
        .rise_o (w_sclk_rise),
        .fall_o (w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cs_ni),
        .q_o    (w_cs_q),
        .rise_o (w_cs_rise),
        .fall_o (w_cs_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_mosi_sync <= '0;
        else         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // The cs synchronizer resets to "deselected"; if cs_ni is already low at
    // reset release that would look like a falling edge. Only accept a frame
    // start once a real high level has been seen after the chain has flushed.
    assign w_flushed = (r_flush_cnt == FLUSH_MAX);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            if (!w_flushed) r_flush_cnt <= r_flush_cnt + 1'b1;
            r_armed <= r_armed | (w_flushed & w_cs_q);
        end
    end

    assign w_start     = (r_state == IDLE) && w_cs_fall && r_armed;
    assign w_end       = (r_state == XFER) && w_cs_rise;
    assign w_shift_in  = (r_state == XFER) && !w_cs_rise && w_sclk_rise;
    assign w_fall_act  = (r_state == XFER) && !w_cs_rise && w_sclk_fall;
    assign w_reload    = w_fall_act && (r_bit_cnt == 3'd0);
    assign w_load      = w_start || w_reload;
    assign w_load_byte = r_hold_full ? r_hold : FILL_BYTE;

    // tx_valid_i/tx_ready_o: a byte is accepted on every clk_i edge where both
    // are high; tx_ready_o stays low while the holding register is occupied.
    assign w_wr = tx_valid_i && !r_hold_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_miso_oe   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_rx_valid  <= 1'b0;
            if (w_start) begin
                r_state   <= XFER;
                r_bit_cnt <= 3'd0;
                r_miso_oe <= 1'b1;
            end else if (w_end) begin
                r_state     <= IDLE;
                r_bit_cnt   <= 3'd0;
                r_miso_oe   <= 1'b0;
                r_frame_err <= (r_bit_cnt != 3'd0);
                r_rx_shift  <= '0;
            end else if (w_shift_in) begin
                r_rx_shift <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_shift    <= '0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_load) begin
                r_tx_shift    <= w_load_byte;
                r_tx_underrun <= !r_hold_full;
            end else if (w_fall_act) begin
                r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    // A write can only land while empty, so it never collides with a load
    // consuming a full register; a write during an underrun load is kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_wr) begin
            r_hold      <= tx_data_i;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    assign miso_o        = r_miso_oe & r_tx_shift[SPI_BYTE_W-1];
    assign miso_oe_o     = r_miso_oe;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_ready_o    = !r_hold_full;
    assign tx_underrun_o = r_tx_underrun;
    assign frame_err_o   = r_frame_err;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master driver, a TX feeder and two
// monitors (RX byte, MISO byte) checking against expected queues.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H = 8;  // sclk half period in clk cycles

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk = 1'b0;
    logic           cs_n = 1'b1;
    logic           mosi = 1'b0;
    logic [7:0]     tx_data = 8'h00;
    logic           tx_valid = 1'b0;
    logic           miso_o, miso_oe_o, rx_valid_o, tx_ready_o, tx_underrun_o, frame_err_o;
    logic [7:0]     rx_data_o;
    spi_slv_state_t dbg_state_o;

    spi_slave #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sclk_i        (sclk),
        .cs_ni         (cs_n),
        .mosi_i        (mosi),
        .miso_o        (miso_o),
        .miso_oe_o     (miso_oe_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready_o),
        .tx_underrun_o (tx_underrun_o),
        .frame_err_o   (frame_err_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    int         rx_cnt = 0;
    int         underrun_cnt = 0;
    int         ferr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid_o) begin
            rx_cnt++;
            if (exp_rx_q.size() == 0) begin
                fail_now("rx_unexpected", $sformatf("got %02h with nothing expected", rx_data_o));
            end else begin
                e = exp_rx_q.pop_front();
                check("rx_data", 32'(rx_data_o), 32'(e));
            end
        end
        if (tx_underrun_o) underrun_cnt++;
        if (frame_err_o)   ferr_cnt++;
    end

    logic [7:0] mon_sr = 8'h00;
    int         mon_bits = 0;
    always @(posedge sclk or posedge cs_n) begin
        logic [7:0] e;
        if (cs_n) begin
            mon_bits = 0;
        end else begin
            check("miso_oe_in_frame", 32'(miso_oe_o), 32'd1);
            mon_sr = {mon_sr[6:0], miso_o};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_miso_q.size() == 0) begin
                    fail_now("miso_unexpected", $sformatf("master captured %02h", mon_sr));
                end else begin
                    e = exp_miso_q.pop_front();
                    check("miso_byte", 32'(mon_sr), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int t;
        t = 0;
        while (!tx_ready_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready_o) begin
            fail_now("tx_ready_timeout", $sformatf("tx_ready_o stayed 0 for byte %02h", b));
        end else begin
            tx_data  = b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    // Clocks n bits MSB first; with hold_high the last sclk stays high so the
    // frame can be closed before the trailing falling edge.
    task automatic spi_bits(input logic [7:0] b, input int n, input bit hold_high);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_clks(H);
            sclk = 1'b1;
            wait_clks(H);
            if (!(hold_high && i == n - 1)) sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clks(H);
        check("miso_oe_start", 32'(miso_oe_o), 32'd1);
        check("state_xfer", 32'(dbg_state_o), 32'(XFER));
    endtask

    task automatic frame_end();
        wait_clks(H);
        cs_n = 1'b1;
        wait_clks(6);
        sclk = 1'b0;
        wait_clks(H);
        check("miso_oe_end", 32'(miso_oe_o), 32'd0);
        check("miso_end", 32'(miso_o), 32'd0);
        check("state_idle", 32'(dbg_state_o), 32'(IDLE));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(miso_o), 32'd0);
        check({tag, "_miso_oe"},  32'(miso_oe_o), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data_o), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
        check({tag, "_underrun"}, 32'(tx_underrun_o), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err_o), 32'd0);
        check({tag, "_state"},    32'(dbg_state_o), 32'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    int rx0, ur0, fe0;

    initial begin
        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(5);

        // Queued byte, single frame
        push_tx(8'hA5);
        check("tx_ready_full", 32'(tx_ready_o), 32'd0);
        exp_miso_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        rx0 = rx_cnt; ur0 = underrun_cnt;
        frame_start();
        check("tx_ready_after_load", 32'(tx_ready_o), 32'd1);
        spi_bits(8'h3C, 8, 1'b1);
        frame_end();
        check("t1_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("t1_underrun", 32'(underrun_cnt - ur0), 32'd0);

        // Empty holding register -> fill byte
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h00);
        rx0 = rx_cnt; ur0 = underrun_cnt;
        frame_start();
        spi_bits(8'h00, 8, 1'b1);
        frame_end();
        check("t2_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("t2_underrun", 32'(underrun_cnt - ur0), 32'd1);

        // Back-to-back bytes with refill
        push_tx(8'h11);
        exp_miso_q.push_back(8'h11);
        exp_miso_q.push_back(8'h22);
        exp_miso_q.push_back(8'h33);
        exp_rx_q.push_back(8'h01);
        exp_rx_q.push_back(8'h02);
        exp_rx_q.push_back(8'h03);
        rx0 = rx_cnt; ur0 = underrun_cnt;
        fork
            begin
                push_tx(8'h22);
                push_tx(8'h33);
            end
            begin
                frame_start();
                spi_bits(8'h01, 8, 1'b0);
                spi_bits(8'h02, 8, 1'b0);
                spi_bits(8'h03, 8, 1'b1);
                frame_end();
            end
        join
        check("t3_rx_pulses", 32'(rx_cnt - rx0), 32'd3);
        check("t3_underrun", 32'(underrun_cnt - ur0), 32'd0);

        // Partial byte -> frame error, then a clean frame
        rx0 = rx_cnt; fe0 = ferr_cnt;
        frame_start();
        spi_bits(8'hF0, 5, 1'b0);
        frame_end();
        check("t4_frame_err", 32'(ferr_cnt - fe0), 32'd1);
        check("t4_no_rx", 32'(rx_cnt - rx0), 32'd0);
        push_tx(8'hC3);
        exp_miso_q.push_back(8'hC3);
        exp_rx_q.push_back(8'h5A);
        rx0 = rx_cnt; fe0 = ferr_cnt;
        frame_start();
        spi_bits(8'h5A, 8, 1'b1);
        frame_end();
        check("t4b_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("t4b_frame_err", 32'(ferr_cnt - fe0), 32'd0);

        // Reset in the middle of a byte
        push_tx(8'h96);
        rx0 = rx_cnt; fe0 = ferr_cnt;
        frame_start();
        spi_bits(8'h55, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);
        check("reset_no_reentry", 32'(miso_oe_o), 32'd0);
        cs_n = 1'b1;
        wait_clks(10);
        check("t5_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("t5_no_frame_err", 32'(ferr_cnt - fe0), 32'd0);
        push_tx(8'hE7);
        exp_miso_q.push_back(8'hE7);
        exp_rx_q.push_back(8'h81);
        rx0 = rx_cnt; ur0 = underrun_cnt;
        frame_start();
        spi_bits(8'h81, 8, 1'b1);
        frame_end();
        check("t5b_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("t5b_underrun", 32'(underrun_cnt - ur0), 32'd0);

        // sclk activity while deselected is ignored
        rx0 = rx_cnt; ur0 = underrun_cnt; fe0 = ferr_cnt;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            wait_clks(H);
            sclk = 1'b1;
            wait_clks(H);
            check("t6_oe_idle", 32'(miso_oe_o), 32'd0);
            sclk = 1'b0;
        end
        wait_clks(2 * H);
        check("t6_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("t6_no_underrun", 32'(underrun_cnt - ur0), 32'd0);
        check("t6_no_frame_err", 32'(ferr_cnt - fe0), 32'd0);
        check("t6_state", 32'(dbg_state_o), 32'(IDLE));

        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter FILL_BYTE, default 8'hFF, meaning the byte shifted out when no TX data is queued.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for sclk_i, cs_ni and mosi_i.
REQ-003 clk_i  input  1  system clock; the only clock in the block.
REQ-004 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-005 sclk_i  input  1  SPI serial clock from master; asynchronous to clk_i.
REQ-006 cs_ni  input  1  chip select; active-low; asynchronous.
REQ-007 mosi_i  input  1  master-out data, MSB first.
REQ-008 miso_o  output  1  slave-out data, MSB first.
REQ-009 miso_oe_o  output  1  MISO output enable; pad tristates when 0.
REQ-010 rx_data_o  output  8  last complete received byte.
REQ-011 rx_valid_o  output  1  one-cycle pulse; rx_data_o updated.
REQ-012 tx_data_i  input  8  byte to queue for transmission.
REQ-013 tx_valid_i  input  1  tx_data_i valid.
REQ-014 tx_ready_o  output  1  TX holding register empty.
REQ-015 tx_underrun_o  output  1  one-cycle pulse; FILL_BYTE substituted for a byte.
REQ-016 frame_err_o  output  1  one-cycle pulse; cs_ni deasserted mid-byte.

Function
REQ-017 SHALL implement SPI mode 0 (CPOL=0, CPHA=0): sample MOSI on sclk rising edge, change MISO on sclk falling edge.
REQ-018 SHALL synchronize sclk_i, cs_ni and mosi_i through SYNC_STAGES flops; edges are detected on synchronized values; supported sclk_i frequency is at most clk_i/8.
REQ-019 SHALL use FSM states IDLE and XFER; IDLE->XFER on synchronized cs_ni falling edge; XFER->IDLE on synchronized cs_ni rising edge.
REQ-020 On IDLE->XFER, SHALL load the TX shift register from the holding register if full; otherwise load FILL_BYTE and pulse tx_underrun_o. SHALL drive bit 7 on miso_o and set miso_oe_o=1 in the same cycle.
REQ-021 In XFER, each sclk rising edge SHALL shift mosi into the RX shift register LSB and increment a 3-bit bit counter.
REQ-022 On the rising edge that completes bit 8, SHALL copy the RX shift register to rx_data_o and pulse rx_valid_o in the next clk_i cycle. Counter wraps 7->0.
REQ-023 Each sclk falling edge SHALL shift the TX register left. The falling edge after bit 8 SHALL reload the TX register per REQ-020 rule, enabling back-to-back bytes.
REQ-024 tx_ready_o SHALL be 1 when the holding register is empty. tx_valid_i && tx_ready_o writes it. A write and a TX-register load in the same cycle: the load takes the old content (or FILL_BYTE); the write is kept for the next byte.
REQ-025 rx_valid_o has no backpressure; a byte not consumed is overwritten by the next.
REQ-026 cs_ni rising edge with bit counter != 0 SHALL pulse frame_err_o, discard the partial byte, and generate no rx_valid_o. In all cases it SHALL clear the counter and set miso_oe_o=0; miso_o=0.
REQ-027 sclk edges in IDLE SHALL be ignored.
REQ-028 The holding register contents SHALL survive a frame end and be sent first in the next frame.

Reset
REQ-029 rst_ni low SHALL asynchronously force: FSM=IDLE, counter=0, shift registers=0, holding register empty, synchronizer flops to idle levels (sclk 0, cs_n 1), miso_o=0, miso_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, tx_underrun_o=0, frame_err_o=0.
REQ-030 Reset during XFER SHALL abort the frame without rx_valid_o or frame_err_o. The block re-enters XFER only on a fresh cs_ni falling edge after release.

Structure
REQ-031 Package spi_pkg SHALL hold SPI_BYTE_W=8, the default FILL_BYTE, and the state enum spi_slv_state_t {IDLE, XFER}.
REQ-032 One sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall pulse outputs; it is instantiated for sclk_i and cs_ni. mosi_i uses the synchronizer only.

Verification
REQ-033 Queue 8'hA5, send one frame with master byte 8'h3C -> rx_data_o=8'h3C with one rx_valid_o pulse; miso bits 1,0,1,0,0,1,0,1; no tx_underrun_o.
REQ-034 Frame with empty holding register, master byte 8'h00 -> miso all 1s (8'hFF); tx_underrun_o pulses once.
REQ-035 Back-to-back 3 bytes 8'h01,8'h02,8'h03 with TX 8'h11,8'h22,8'h33 refilled when tx_ready_o=1 -> three rx_valid_o pulses with matching values; master captures 11,22,33.
REQ-036 Raise cs_ni after 5 bits -> frame_err_o pulse, no rx_valid_o, miso_oe_o=0; next full frame receives correctly.
REQ-037 Assert rst_ni low mid-byte -> all outputs at reset values immediately; tx_ready_o=1; next frame is correct.
REQ-038 Toggle sclk_i with cs_ni high -> no rx_valid_o, miso_oe_o stays 0.
